// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential divider: FSM state encodings and
// the iteration-counter width helper.
package div_seq_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // The counter must be able to represent 0..width.
  function automatic int div_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_sub_step.sv
// One restoring-division step: compares the shifted partial remainder with the
// divisor and produces the reduced remainder candidate.
module div_sub_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_shift,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] diff,
  output logic             ge
);

  // rem_shift carries one extra bit, so divisors above 2^(WIDTH-1) cannot lose the
  // shifted-out MSB. When ge is set, the difference always fits in WIDTH bits.
  assign ge   = (rem_shift >= {1'b0, divisor});
  assign diff = rem_shift[WIDTH-1:0] - divisor;

endmodule

// File: rtl/div_seq.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// Optional feature macro: DIV_SIGNED_EN (adds signed_op, two's-complement mode).
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
  input  logic             signed_op,
`endif
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CNT_W = div_cnt_width(WIDTH);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zero_q, zero_d;
  logic             dbz_q, dbz_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

`ifdef DIV_SIGNED_EN
  assign a_neg = signed_op & dividend[WIDTH-1];
  assign b_neg = signed_op & divisor[WIDTH-1];
`else
  assign a_neg = 1'b0;
  assign b_neg = 1'b0;
`endif

  // The most-negative value maps to itself, which as an unsigned magnitude is correct.
  assign a_mag = a_neg ? (-dividend) : dividend;
  assign b_mag = b_neg ? (-divisor) : divisor;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] step_diff;
  logic             step_ge;
  logic [WIDTH-1:0] step_acc;
  logic [WIDTH-1:0] step_q;

  assign rem_shift = {acc_q, q_q[WIDTH-1]};

  div_sub_step #(.WIDTH(WIDTH)) u_step (
    .rem_shift(rem_shift),
    .divisor  (dvs_q),
    .diff     (step_diff),
    .ge       (step_ge)
  );

  assign step_acc = step_ge ? step_diff : rem_shift[WIDTH-1:0];
  assign step_q   = {q_q[WIDTH-2:0], step_ge};

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    acc_d   = acc_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    dbz_d   = dbz_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;

    case (state_q)
      DIV_IDLE, DIV_DONE: begin
        if (start) begin
          state_d = DIV_RUN;
          q_d     = a_mag;
          dvs_d   = b_mag;
          acc_d   = '0;
          cnt_d   = '0;
          zero_d  = (divisor == '0);
          dbz_d   = 1'b0;
          qneg_d  = a_neg ^ b_neg;
          rneg_d  = a_neg;
        end else if (state_q == DIV_DONE) begin
          state_d = DIV_IDLE;
        end
      end
      DIV_RUN: begin
        if (zero_q) begin
          // Divide-by-zero skips iteration; q_q still holds the dividend magnitude.
          state_d = DIV_DONE;
          quo_d   = '1;
          rem_d   = rneg_q ? (-q_q) : q_q;
          dbz_d   = 1'b1;
        end else begin
          q_d   = step_q;
          acc_d = step_acc;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = DIV_DONE;
            quo_d   = qneg_q ? (-step_q) : step_q;
            rem_d   = rneg_q ? (-step_acc) : step_acc;
          end
        end
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      q_q     <= '0;
      acc_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      dbz_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      acc_q   <= acc_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      dbz_q   <= dbz_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign busy        = (state_q == DIV_RUN);
  assign done        = (state_q == DIV_DONE);
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: arithmetic reference model compared every
// cycle, plus directed operations with hand-computed results.
module tb_div_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         signed_op = 1'b0;
  logic [W-1:0] quotient, remainder;
  logic         busy, done, div_by_zero;

  int total = 0;
  int bad = 0;
  int cyc_cnt = 0;
  int t_acc = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  div_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
`ifdef DIV_SIGNED_EN
    .signed_op  (signed_op),
`endif
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  // Reference result {quotient, remainder} from plain arithmetic.
  function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
    logic sg;
    logic [W-1:0] q, r;
`ifdef DIV_SIGNED_EN
    sg = s;
`else
    sg = s & 1'b0;
`endif
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (sg) begin
      if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
        q = a;
        r = '0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  logic         m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0, m_pdz = 1'b0;
  logic [W-1:0] m_q = '0, m_r = '0;
  logic [2*W-1:0] m_pend = '0;
  int           m_left = 0;

  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_dz   <= 1'b0;
      m_q    <= '0;
      m_r    <= '0;
      m_left <= 0;
    end else if (start && !m_busy) begin
      m_pend <= ref_div(dividend, divisor, signed_op);
      m_pdz  <= (divisor == '0);
      m_busy <= 1'b1;
      m_done <= 1'b0;
      m_dz   <= 1'b0;
      m_left <= (divisor == '0) ? 1 : W;
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_q    <= m_pend[2*W-1:W];
        m_r    <= m_pend[W-1:0];
        m_dz   <= m_pdz;
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_busy", W'(busy), W'(m_busy));
      check("model_done", W'(done), W'(m_done));
      check("model_dbz", W'(div_by_zero), W'(m_dz));
      check("model_quotient", quotient, m_q);
      check("model_remainder", remainder, m_r);
    end
  end

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    start     = 1'b1;
    dividend  = a;
    divisor   = b;
    signed_op = s;
    @(posedge clk);
    #1;
    t_acc    = cyc_cnt;
    start    = 1'b0;
    dividend = 32'hDEAD_BEEF;
    divisor  = 32'h0000_0013;
  endtask

  task automatic wait_done(input string nm, input logic [W-1:0] eq, input logic [W-1:0] er,
                           input logic edz, input int elat);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no done expected done within 200 cycles", nm);
    end else begin
      check({nm, "_latency"}, W'(cyc_cnt - t_acc), W'(elat));
      check({nm, "_quotient"}, quotient, eq);
      check({nm, "_remainder"}, remainder, er);
      check({nm, "_dbz"}, W'(div_by_zero), W'(edz));
      $display("op %s: q=%h r=%h dbz=%b latency=%0d", nm, quotient, remainder, div_by_zero,
               cyc_cnt - t_acc);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("reset_busy", W'(busy), '0);
    check("reset_done", W'(done), '0);
    check("reset_quotient", quotient, '0);
    rst = 1'b0;
    @(negedge clk);

    start_op(32'd100, 32'd7, 1'b0);
    check("accept_busy", W'(busy), 32'd1);
    wait_done("100/7", 32'd14, 32'd2, 1'b0, 32);

    @(negedge clk);
    start_op(32'hFFFF_FFFF, 32'd1, 1'b0);
    wait_done("ffffffff/1", 32'hFFFF_FFFF, 32'd0, 1'b0, 32);
    start_op(32'd9, 32'd3, 1'b0);
    @(negedge clk);
    check("b2b_done_drop", W'(done), '0);
    check("b2b_busy", W'(busy), 32'd1);
    wait_done("9/3_b2b", 32'd3, 32'd0, 1'b0, 32);

    @(negedge clk);
    start_op(32'd5, 32'd0, 1'b0);
    wait_done("5/0", 32'hFFFF_FFFF, 32'd5, 1'b1, 1);
    @(negedge clk);
    check("dbz_held", W'(div_by_zero), 32'd1);
    start_op(32'd8, 32'd2, 1'b0);
    @(negedge clk);
    check("dbz_cleared", W'(div_by_zero), '0);
    wait_done("8/2", 32'd4, 32'd0, 1'b0, 32);

    @(negedge clk);
    start_op(32'd50, 32'd5, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", W'(busy), '0);
    check("abort_done", W'(done), '0);
    check("abort_quotient", quotient, '0);
    check("abort_remainder", remainder, '0);
    start_op(32'd50, 32'd5, 1'b0);
    wait_done("50/5", 32'd10, 32'd0, 1'b0, 32);

    @(negedge clk);
    start_op(32'd1000, 32'd10, 1'b0);
    repeat (5) @(negedge clk);
    start    = 1'b1;
    dividend = 32'd77;
    divisor  = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("1000/10_ignore", 32'd100, 32'd0, 1'b0, 32);

    @(negedge clk);
    start_op(32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
    wait_done("bigdiv", 32'd1, 32'h7FFF_FFFE, 1'b0, 32);
    @(negedge clk);
    start_op(32'd7, 32'd9, 1'b0);
    wait_done("7/9", 32'd0, 32'd7, 1'b0, 32);
    @(negedge clk);
    start_op(32'd123456789, 32'd1000, 1'b0);
    wait_done("123456789/1000", 32'd123456, 32'd789, 1'b0, 32);

`ifdef DIV_SIGNED_EN
    @(negedge clk);
    start_op(32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done("-7/2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 32);
    @(negedge clk);
    start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done("ovf", 32'h8000_0000, 32'd0, 1'b0, 32);
    @(negedge clk);
    start_op(32'd7, 32'hFFFF_FFFE, 1'b1);
    wait_done("7/-2", 32'hFFFF_FFFD, 32'd1, 1'b0, 32);
    @(negedge clk);
    start_op(32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_done("unsigned_mode", 32'h7FFF_FFFC, 32'd1, 1'b0, 32);
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
